// File: rtl/his_builder_fsm_pkg.sv
// Shared defaults and state type for the histogram builder.
package his_builder_fsm_pkg;

  localparam int NB_DEF          = 5;
  localparam int PEAK_MAX_DEF    = 8;
  localparam int ACQ_PER_HIS_DEF = 6;

  typedef enum logic [1:0] {
    COARSE = 2'd0,
    FINE   = 2'd1,
    DONE   = 2'd2
  } his_state_e;

  // Acquisition counter width: must hold values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/his_bin_ram.sv
// Bin storage: 2**NB counters with a read-modify-write increment port and a clear-all.
// Macro HIS_SATURATE_EN: when defined, counters stick at all-ones instead of wrapping.
module his_bin_ram
  import his_builder_fsm_pkg::*;
#(
  parameter int NB       = NB_DEF,
  parameter int PEAK_MAX = PEAK_MAX_DEF
) (
  input  logic                clk,
  input  logic                res,
  input  logic                i_inc,
  input  logic                i_clr,
  input  logic [NB-1:0]       i_addr,
  output logic [PEAK_MAX-1:0] o_new
);

  logic [PEAK_MAX-1:0] r_bins [2**NB];
  logic [PEAK_MAX-1:0] w_cur;

  assign w_cur = r_bins[i_addr];

`ifdef HIS_SATURATE_EN
  assign o_new = (&w_cur) ? w_cur : w_cur + 1'b1;
`else
  assign o_new = w_cur + 1'b1;
`endif

  // Clear dominates so the completing write is counted only on o_new.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < 2**NB; i++) r_bins[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < 2**NB; i++) r_bins[i] <= '0;
    end else if (i_inc) begin
      r_bins[i_addr] <= o_new;
    end
  end

endmodule

// File: rtl/his_builder_fsm.sv
// Two-pass histogram builder (coarse then fine) with per-histogram acquisition count.
// Macro HIS_SATURATE_EN selects saturating bin counters (default: wrap).
module his_builder_fsm
  import his_builder_fsm_pkg::*;
#(
  parameter int NB          = NB_DEF,
  parameter int PEAK_MAX    = PEAK_MAX_DEF,
  parameter int ACQ_PER_HIS = ACQ_PER_HIS_DEF
) (
  input  logic                clk,
  input  logic                res,
  input  logic                wrEn,
  input  logic [NB-1:0]       addr,
  output logic [PEAK_MAX-1:0] binCounts,
  output logic                acq_count_finish,
  output logic                hisNum
);

  localparam int CW = cnt_width(ACQ_PER_HIS);

  his_state_e          r_state;
  logic [CW-1:0]       r_acq;
  logic                w_accept;
  logic                w_last;
  logic                w_clr;
  logic [PEAK_MAX-1:0] w_new;

  assign w_accept = wrEn && (r_state != DONE);
  assign w_last   = w_accept && (r_acq == CW'(ACQ_PER_HIS - 1));
  assign w_clr    = w_last && (r_state == COARSE);

  his_bin_ram #(
    .NB       (NB),
    .PEAK_MAX (PEAK_MAX)
  ) u_bins (
    .clk    (clk),
    .res    (res),
    .i_inc  (w_accept),
    .i_clr  (w_clr),
    .i_addr (addr),
    .o_new  (w_new)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state          <= COARSE;
      r_acq            <= '0;
      binCounts        <= '0;
      acq_count_finish <= 1'b0;
      hisNum           <= 1'b0;
    end else begin
      acq_count_finish <= w_last;
      if (w_accept) binCounts <= w_new;
      if (w_last) begin
        r_acq  <= '0;
        hisNum <= 1'b1;
        case (r_state)
          COARSE:  r_state <= FINE;
          FINE:    r_state <= DONE;
          default: r_state <= r_state;
        endcase
      end else if (w_accept) begin
        r_acq <= r_acq + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_his_builder_fsm.sv
// Directed table-driven bench for his_builder_fsm (default build plus a PEAK_MAX=2 instance).
module tb_his_builder_fsm;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       wrEn = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] binCounts;
  logic       acq_count_finish;
  logic       hisNum;

  logic       wr2 = 1'b0;
  logic [4:0] addr2 = '0;
  logic [1:0] bc2;
  logic       fin2;
  logic       his2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  his_builder_fsm dut (
    .clk              (clk),
    .res              (res),
    .wrEn             (wrEn),
    .addr             (addr),
    .binCounts        (binCounts),
    .acq_count_finish (acq_count_finish),
    .hisNum           (hisNum)
  );

  his_builder_fsm #(.NB(5), .PEAK_MAX(2), .ACQ_PER_HIS(6)) dut_sat (
    .clk              (clk),
    .res              (res),
    .wrEn             (wr2),
    .addr             (addr2),
    .binCounts        (bc2),
    .acq_count_finish (fin2),
    .hisNum           (his2)
  );

  typedef struct packed {
    logic       wr;
    logic [4:0] a;
    logic [7:0] bc;
    logic       fin;
    logic       his;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk3(input string name, input int bc, input int fin, input int his);
    chk({name, ".binCounts"}, int'(binCounts), bc);
    chk({name, ".finish"}, int'(acq_count_finish), fin);
    chk({name, ".hisNum"}, int'(hisNum), his);
  endtask

  // Called from #1 after a posedge; returns #1 after the next posedge.
  task automatic drive(input logic wr, input logic [4:0] a);
    wrEn = wr;
    addr = a;
    @(posedge clk);
    #1;
    wrEn = 1'b0;
  endtask

  task automatic do_reset();
    res = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b1;
  endtask

  initial begin
    logic [1:0] sat_exp [5];
`ifdef HIS_SATURATE_EN
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif

    tbl[0]  = '{1'b1, 5'd3,  8'd1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'd3,  8'd2, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd3,  8'd3, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd3,  8'd3, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 5'd7,  8'd1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 5'd7,  8'd2, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 5'd3,  8'd4, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 5'd0,  8'd4, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 5'd3,  8'd1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 5'd5,  8'd1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 5'd3,  8'd2, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 5'd3,  8'd3, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 5'd5,  8'd2, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 5'd9,  8'd1, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 5'd31, 8'd1, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 5'd31, 8'd1, 1'b0, 1'b1};

    // Reset values, then a single coarse write.
    #2;
    chk3("reset", 0, 0, 0);
    do_reset();
    drive(1'b1, 5'd12);
    $display("txn first addr=12 bc=%0d fin=%0d his=%0d", binCounts, acq_count_finish, hisNum);
    chk3("first_write", 1, 0, 0);

    // Coarse histogram, transition, fine histogram, DONE.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].wr, tbl[i].a);
      $display("txn vec%0d wr=%0d addr=%0d bc=%0d fin=%0d his=%0d", i, tbl[i].wr, tbl[i].a,
               binCounts, acq_count_finish, hisNum);
      chk3($sformatf("vec%0d", i), int'(tbl[i].bc), int'(tbl[i].fin), int'(tbl[i].his));
    end

    // Asynchronous reset out of DONE.
    res = 1'b0;
    #1;
    $display("txn async_reset_done bc=%0d fin=%0d his=%0d", binCounts, acq_count_finish, hisNum);
    chk3("async_reset_done", 0, 0, 0);
    @(posedge clk);
    #1;
    res = 1'b1;

    // Reset mid-histogram discards partial counts.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1);
      $display("txn partial%0d bc=%0d", i, binCounts);
      chk($sformatf("partial%0d.binCounts", i), int'(binCounts), i + 1);
    end
    #2;
    res = 1'b0;
    #1;
    $display("txn async_reset_mid bc=%0d fin=%0d his=%0d", binCounts, acq_count_finish, hisNum);
    chk3("async_reset_mid", 0, 0, 0);
    @(posedge clk);
    #1;
    res = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd1);
      $display("txn restart%0d bc=%0d fin=%0d his=%0d", i, binCounts, acq_count_finish, hisNum);
      chk3($sformatf("restart%0d", i), i + 1, (i == 5) ? 1 : 0, (i == 5) ? 1 : 0);
    end

    // Overflow behaviour on a 2-bit counter instance.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr2 = 1'b1;
      addr2 = 5'd0;
      @(posedge clk);
      #1;
      wr2 = 1'b0;
      $display("txn sat%0d bc=%0d fin=%0d", i, bc2, fin2);
      chk($sformatf("sat%0d.binCounts", i), int'(bc2), int'(sat_exp[i]));
      chk($sformatf("sat%0d.finish", i), int'(fin2), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
